kredi_takip: RTL

Loan-balance tracker that sits directly downstream of the interest-rate stage and consumes its 6-bit percent rate output `faiz`. Each period tick it accrues interest on the outstanding balance, then applies a fixed installment. It reports the balance, the elapsed period count, and the terminal status: paid off, default, or saturation.

---
 rtl/kredi_takip_pkg.sv | 25 ++
 rtl/kredi_takip_faiz_ekle.sv | 29 ++
 rtl/kredi_takip.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/kredi_takip_pkg.sv
// Shared definitions for the loan-balance tracker: FSM state encoding,
// the percent divisor and a state-classification helper.
package kredi_takip_pkg;

   typedef logic [2:0] durum_t;

   localparam durum_t S_IDLE     = 3'd0;
   localparam durum_t S_BEKLE    = 3'd1;
   localparam durum_t S_FAIZ     = 3'd2;
   localparam durum_t S_ODEME    = 3'd3;
   localparam durum_t S_BITTI    = 3'd4;
   localparam durum_t S_TEMERRUT = 3'd5;

   localparam logic [6:0] YUZDE = 7'd100;

   function automatic logic aktif_mi(input durum_t d);
      logic sonuc;
      case (d)
         S_BEKLE, S_FAIZ, S_ODEME: sonuc = 1'b1;
         default:                  sonuc = 1'b0;
      endcase
      return sonuc;
   endfunction

endpackage

// File: rtl/kredi_takip_faiz_ekle.sv
// Combinational interest accrual: balance + floor(balance*rate/100),
// saturating to all-ones with an overflow flag.
module kredi_takip_faiz_ekle
   import kredi_takip_pkg::*;
#(
   parameter int GENISLIK = 16
) (
   input  logic [GENISLIK-1:0] i_bakiye,
   input  logic [5:0]          i_faiz,
   output logic [GENISLIK-1:0] o_bakiye,
   output logic                o_tasma
);

   localparam logic [GENISLIK+5:0] L_YUZDE = (GENISLIK+6)'(YUZDE);

   logic [GENISLIK+5:0] w_carpim;
   logic [GENISLIK+5:0] w_bolum;
   logic [GENISLIK:0]   w_toplam;

   assign w_carpim = {6'd0, i_bakiye} * {{GENISLIK{1'b0}}, i_faiz};
   assign w_bolum  = w_carpim / L_YUZDE;
   assign w_toplam = {1'b0, i_bakiye} + w_bolum[GENISLIK:0];

   // Upper quotient bits are always zero for 6-bit rates, but are folded in
   // so nothing is silently dropped if the rate width ever grows.
   assign o_tasma  = w_toplam[GENISLIK] | (|w_bolum[GENISLIK+5:GENISLIK+1]);
   assign o_bakiye = o_tasma ? {GENISLIK{1'b1}} : w_toplam[GENISLIK-1:0];

endmodule

// File: rtl/kredi_takip.sv
// Loan-balance tracker: per period tick accrues interest, then applies a
// fixed installment; reports balance, period count and terminal status.
module kredi_takip
   import kredi_takip_pkg::*;
#(
   parameter int GENISLIK  = 16,
   parameter int SAYAC_GEN = 8,
   parameter int MAX_DONEM = 24
) (
   input  logic                 saat,
   input  logic                 reset,
   input  logic                 basla,
   input  logic [GENISLIK-1:0]  anapara,
   input  logic [GENISLIK-1:0]  taksit,
   input  logic [5:0]           faiz,
   input  logic                 donem_tik,
   output logic [GENISLIK-1:0]  bakiye,
   output logic [SAYAC_GEN-1:0] donem_sayisi,
   output logic                 aktif,
   output logic                 bitti,
   output logic                 temerrut,
   output logic                 tasma
);

   localparam logic [SAYAC_GEN-1:0] L_SINIR = SAYAC_GEN'(MAX_DONEM);
   localparam logic [SAYAC_GEN-1:0] L_BIR   = {{(SAYAC_GEN-1){1'b0}}, 1'b1};

   durum_t               r_durum,    w_durum_n;
   logic [GENISLIK-1:0]  r_bakiye,   w_bakiye_n;
   logic [GENISLIK-1:0]  r_taksit,   w_taksit_n;
   logic [SAYAC_GEN-1:0] r_sayac,    w_sayac_n;
   logic                 r_bitti,    w_bitti_n;
   logic                 r_temerrut, w_temerrut_n;
   logic                 r_tasma,    w_tasma_n;
   logic                 r_aktif,    w_aktif_n;
   logic [GENISLIK-1:0]  w_faizli;
   logic                 w_faiz_tasma;

   kredi_takip_faiz_ekle #(.GENISLIK(GENISLIK)) u_faiz_ekle (
      .i_bakiye (r_bakiye),
      .i_faiz   (faiz),
      .o_bakiye (w_faizli),
      .o_tasma  (w_faiz_tasma)
   );

   // Next-state and next-output computation for the loan FSM.
   always_comb begin
      w_durum_n    = r_durum;
      w_bakiye_n   = r_bakiye;
      w_taksit_n   = r_taksit;
      w_sayac_n    = r_sayac;
      w_bitti_n    = r_bitti;
      w_temerrut_n = r_temerrut;
      w_tasma_n    = r_tasma;
      case (r_durum)
         S_IDLE, S_BITTI, S_TEMERRUT: begin
            if (basla) begin
               w_bakiye_n   = anapara;
               w_taksit_n   = taksit;
               w_sayac_n    = {SAYAC_GEN{1'b0}};
               w_temerrut_n = 1'b0;
               w_tasma_n    = 1'b0;
               if (anapara == {GENISLIK{1'b0}}) begin
                  w_bitti_n = 1'b1;
                  w_durum_n = S_BITTI;
               end else begin
                  w_bitti_n = 1'b0;
                  w_durum_n = S_BEKLE;
               end
            end else begin
               w_durum_n = r_durum;
            end
         end
         S_BEKLE: begin
            if (donem_tik) begin
               w_durum_n = S_FAIZ;
            end else begin
               w_durum_n = S_BEKLE;
            end
         end
         S_FAIZ: begin
            w_bakiye_n = w_faizli;
            w_tasma_n  = r_tasma | w_faiz_tasma;
            w_durum_n  = S_ODEME;
         end
         S_ODEME: begin
            if (r_sayac != L_SINIR) begin
               w_sayac_n = r_sayac + L_BIR;
            end else begin
               w_sayac_n = r_sayac;
            end
            // Payoff wins over default when both land on the same period.
            if (r_bakiye <= r_taksit) begin
               w_bakiye_n = {GENISLIK{1'b0}};
               w_bitti_n  = 1'b1;
               w_durum_n  = S_BITTI;
            end else begin
               w_bakiye_n = r_bakiye - r_taksit;
               if (w_sayac_n == L_SINIR) begin
                  w_temerrut_n = 1'b1;
                  w_durum_n    = S_TEMERRUT;
               end else begin
                  w_durum_n = S_BEKLE;
               end
            end
         end
         default: begin
            w_durum_n = S_IDLE;
         end
      endcase
      w_aktif_n = aktif_mi(w_durum_n);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge saat) begin
      if (reset) begin
         r_durum    <= S_IDLE;
         r_bakiye   <= {GENISLIK{1'b0}};
         r_taksit   <= {GENISLIK{1'b0}};
         r_sayac    <= {SAYAC_GEN{1'b0}};
         r_bitti    <= 1'b0;
         r_temerrut <= 1'b0;
         r_tasma    <= 1'b0;
         r_aktif    <= 1'b0;
      end else begin
         r_durum    <= w_durum_n;
         r_bakiye   <= w_bakiye_n;
         r_taksit   <= w_taksit_n;
         r_sayac    <= w_sayac_n;
         r_bitti    <= w_bitti_n;
         r_temerrut <= w_temerrut_n;
         r_tasma    <= w_tasma_n;
         r_aktif    <= w_aktif_n;
      end
   end

   assign bakiye       = r_bakiye;
   assign donem_sayisi = r_sayac;
   assign aktif        = r_aktif;
   assign bitti        = r_bitti;
   assign temerrut     = r_temerrut;
   assign tasma        = r_tasma;

endmodule
